// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer.
//   state_t         : trial FSM states
//   DELAY_W, RT_W   : widths of the pre-stimulus delay counter and the reaction count
//   DEF_MIN_DELAY   : default fixed pre-stimulus delay (timer_clk cycles, ms)
//   DEF_MAX_RT      : default saturation/timeout value of the reaction count
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REACT,
        DONE,
        EARLY
    } state_t;

    localparam int DELAY_W       = 12;
    localparam int RT_W          = 14;
    localparam int DEF_MIN_DELAY = 1000;
    localparam int DEF_MAX_RT    = 9999;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level that is already synchronous to clk.
//   clk   : block clock
//   reset : asynchronous active-high reset
//   level : sampled level input
//   rise  : high in the cycle where level is high and was low on the previous edge
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // Combinational against the registered copy so the edge is seen in the
    // same cycle the level first goes high.
    assign rise = level & ~level_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: after start, waits MIN_DELAY + rnd_cnt cycles, lights the
// lamp, then counts cycles until the stop button is pressed (or MAX_RT).
//   timer_clk : 1 kHz block clock
//   reset     : asynchronous active-high reset
//   start     : trial-start button (level)
//   stop      : reaction button (level)
//   rnd_cnt   : free-running random counter, sampled when a trial starts
//   led       : stimulus lamp, high in REACT
//   rt_ms     : latched reaction time, valid while rt_valid
//   rt_valid  : high in DONE
//   early     : high in EARLY (stop pressed before stimulus)
//   timeout   : high in DONE when the count ran out instead of a stop edge
//   busy      : high in WAIT or REACT
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int MIN_DELAY = DEF_MIN_DELAY,
    parameter int MAX_RT    = DEF_MAX_RT
) (
    input  logic             timer_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [10:0]      rnd_cnt,
    output logic             led,
    output logic [RT_W-1:0]  rt_ms,
    output logic             rt_valid,
    output logic             early,
    output logic             timeout,
    output logic             busy
);

    localparam logic [DELAY_W-1:0] MIN_DELAY_V = DELAY_W'(MIN_DELAY);
    localparam logic [RT_W-1:0]    MAX_RT_V    = RT_W'(MAX_RT);

    // Count never passes MAX_RT, so it can never wrap.
    function automatic logic [RT_W-1:0] sat_inc(input logic [RT_W-1:0] v);
        return (v >= MAX_RT_V) ? MAX_RT_V : v + RT_W'(1);
    endfunction

    state_t              state, state_nxt;
    logic [DELAY_W-1:0]  delay_cnt, delay_nxt;
    logic [RT_W-1:0]     rt_cnt, rt_cnt_nxt;
    logic [RT_W-1:0]     rt_ms_r, rt_ms_nxt;
    logic                to_r, to_nxt;
    logic                start_rise, stop_rise;

    edge_detect u_start_edge (
        .clk   (timer_clk),
        .reset (reset),
        .level (start),
        .rise  (start_rise)
    );

    edge_detect u_stop_edge (
        .clk   (timer_clk),
        .reset (reset),
        .level (stop),
        .rise  (stop_rise)
    );

    always_ff @(posedge timer_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            delay_cnt <= '0;
            rt_cnt    <= '0;
            rt_ms_r   <= '0;
            to_r      <= 1'b0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
            rt_cnt    <= rt_cnt_nxt;
            rt_ms_r   <= rt_ms_nxt;
            to_r      <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        delay_nxt  = delay_cnt;
        rt_cnt_nxt = rt_cnt;
        rt_ms_nxt  = rt_ms_r;
        to_nxt     = to_r;
        case (state)
            IDLE, DONE, EARLY: begin
                // rnd_cnt is sampled once here; later changes do not affect the trial.
                if (start_rise) begin
                    delay_nxt = MIN_DELAY_V + {1'b0, rnd_cnt};
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Level, not edge: a stop still held from a previous trial is early too.
                if (stop) begin
                    state_nxt = EARLY;
                end else if (delay_cnt == '0) begin
                    rt_cnt_nxt = '0;
                    state_nxt  = REACT;
                end else begin
                    delay_nxt = delay_cnt - DELAY_W'(1);
                end
            end
            REACT: begin
                // A stop edge on the final count still counts as a real response.
                if (stop_rise) begin
                    rt_ms_nxt = rt_cnt;
                    to_nxt    = 1'b0;
                    state_nxt = DONE;
                end else if (rt_cnt == MAX_RT_V) begin
                    rt_ms_nxt = MAX_RT_V;
                    to_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    rt_cnt_nxt = sat_inc(rt_cnt);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign led      = (state == REACT);
    assign busy     = (state == WAIT) || (state == REACT);
    assign rt_valid = (state == DONE);
    assign early    = (state == EARLY);
    assign timeout  = (state == DONE) && to_r;
    assign rt_ms    = rt_ms_r;

endmodule
